mmio_bus_controller: RTL and testbench

Memory-mapped I/O controller between the single-cycle ARM core's data port and its data-side resources. It decodes the core's data address into data memory or peripheral space, and gates the write strobe to the selected target. It owns the bomb and enemy game registers and a scancode FIFO fed by the PS/2 keyboard controller, and returns the selected read data combinationally so loads complete in the core's single cycle.

---
 rtl/mmio_bus_controller.sv | 119 +++++++++++
 tb/tb_mmio_bus_controller.sv | 171 +++++++++++++++++
 2 files changed

// File: rtl/mmio_bus_controller.sv
// MMIO decoder for the single-cycle core's data port: routes data memory vs. peripherals,
// owns the bomb/enemy registers and a PS/2 scancode FIFO, and returns read data combinationally.
module mmio_bus_controller #(
  parameter int          KB_DEPTH    = 4,
  parameter logic [31:0] BOMB_RESET  = 32'h0,
  parameter logic [31:0] ENEMY_RESET = 32'h0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] data_adr,
  input  logic [31:0] write_data,
  input  logic [31:0] dmem_rdata,
  input  logic [7:0]  kb_code,
  input  logic        kb_valid,
  output logic        dmem_we,
  output logic [31:0] read_data,
  output logic [31:0] bomb_q,
  output logic [31:0] enemy_q,
  output logic        kb_pending
);

  localparam int PTR_W = (KB_DEPTH > 1) ? $clog2(KB_DEPTH) : 1;
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(KB_DEPTH);

  localparam logic [14:0] A_KBDATA = 15'h4000;
  localparam logic [14:0] A_KBSTAT = 15'h4001;
  localparam logic [14:0] A_BOMB   = 15'h4002;
  localparam logic [14:0] A_ENEMY  = 15'h4003;
  localparam logic [14:0] A_KBCTL  = 15'h4004;

  logic [7:0]       fifo_mem [KB_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W:0]   count;
  logic             overflow;

  logic is_periph, is_store, is_load;
  logic sel_kbdata, sel_bomb, sel_enemy, sel_kbctl;
  logic fifo_empty, fifo_full;
  logic do_pop, do_push, do_clear, do_drop;

  // A store takes priority over a load when both strobes are high.
  assign is_periph  = data_adr[16];
  assign is_store   = mem_write;
  assign is_load    = mem_read & ~mem_write;
  assign sel_kbdata = is_periph & (data_adr[16:2] == A_KBDATA);
  assign sel_bomb   = is_periph & (data_adr[16:2] == A_BOMB);
  assign sel_enemy  = is_periph & (data_adr[16:2] == A_ENEMY);
  assign sel_kbctl  = is_periph & (data_adr[16:2] == A_KBCTL);

  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_C);
  assign do_clear   = is_store & sel_kbctl;
  assign do_pop     = is_load & sel_kbdata & ~fifo_empty;
  assign do_push    = kb_valid & (~fifo_full | do_pop);
  assign do_drop    = kb_valid & fifo_full & ~do_pop;

  assign dmem_we    = ~is_periph & mem_write & ~reset;
  assign kb_pending = ~fifo_empty;

  // Zero-latency read mux for the single-cycle core.
  always_comb begin
    read_data = 32'h0;
    if (!is_periph) begin
      read_data = dmem_rdata;
    end else begin
      case (data_adr[16:2])
        A_KBDATA: read_data = fifo_empty ? 32'h0 : {24'h0, fifo_mem[rd_ptr]};
        A_KBSTAT: read_data = {25'h0, 5'(count), overflow, ~fifo_empty};
        A_BOMB:   read_data = bomb_q;
        A_ENEMY:  read_data = enemy_q;
        default:  read_data = 32'h0;
      endcase
    end
  end

  // Game registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      bomb_q  <= BOMB_RESET;
      enemy_q <= ENEMY_RESET;
    end else begin
      if (is_store && sel_bomb)  bomb_q  <= write_data;
      if (is_store && sel_enemy) enemy_q <= write_data;
    end
  end

  // FIFO control; a KBCTL store overrides any coincident push or pop.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (do_clear) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_drop) overflow <= 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + (PTR_W + 1)'(1);
        2'b01:   count <= count - (PTR_W + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Scancode storage; contents are don't-care outside the valid window.
  always_ff @(posedge clk) begin
    if (do_push && !do_clear) fifo_mem[wr_ptr] <= kb_code;
  end

endmodule

// File: tb/tb_mmio_bus_controller.sv
// Self-checking bench for mmio_bus_controller: expected load data is queued as stimulus
// is driven and compared when the combinational read data is sampled.
module tb_mmio_bus_controller;

  logic        clk = 1'b0;
  logic        reset;
  logic        mem_write, mem_read, kb_valid;
  logic [31:0] data_adr, write_data, dmem_rdata;
  logic [7:0]  kb_code;
  logic        dmem_we, kb_pending;
  logic [31:0] read_data, bomb_q, enemy_q;

  int n_checks = 0;
  int n_fail   = 0;
  logic [31:0] exp_q [$];

  localparam logic [31:0] KBDATA = 32'h0001_0000;
  localparam logic [31:0] KBSTAT = 32'h0001_0004;
  localparam logic [31:0] BOMB   = 32'h0001_0008;
  localparam logic [31:0] ENEMY  = 32'h0001_000C;
  localparam logic [31:0] KBCTL  = 32'h0001_0010;

  mmio_bus_controller #(.KB_DEPTH(4), .BOMB_RESET(32'h0), .ENEMY_RESET(32'h0)) dut (
    .clk(clk), .reset(reset), .mem_write(mem_write), .mem_read(mem_read),
    .data_adr(data_adr), .write_data(write_data), .dmem_rdata(dmem_rdata),
    .kb_code(kb_code), .kb_valid(kb_valid), .dmem_we(dmem_we), .read_data(read_data),
    .bomb_q(bomb_q), .enemy_q(enemy_q), .kb_pending(kb_pending)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    mem_write = 1'b0; mem_read = 1'b0; data_adr = 32'h0;
    write_data = 32'h0; kb_valid = 1'b0; kb_code = 8'h0;
  endtask

  // One core cycle: drive, sample at negedge, then step past the rising edge.
  task automatic op(input logic w, input logic r, input logic [31:0] a, input logic [31:0] d,
                    input logic kv, input logic [7:0] kc, input logic chk_rd,
                    input logic [31:0] exp_rd, input logic exp_we, input string tag);
    logic [31:0] e;
    mem_write = w; mem_read = r; data_adr = a; write_data = d;
    kb_valid = kv; kb_code = kc;
    if (chk_rd) exp_q.push_back(exp_rd);
    @(negedge clk);
    chk({tag, "_we"}, {31'h0, dmem_we}, {31'h0, exp_we});
    if (chk_rd) begin
      e = exp_q.pop_front();
      chk(tag, read_data, e);
    end
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic store(input logic [31:0] a, input logic [31:0] d, input string tag);
    op(1'b1, 1'b0, a, d, 1'b0, 8'h0, 1'b0, 32'h0, 1'b0, tag);
  endtask

  task automatic load(input logic [31:0] a, input logic [31:0] exp, input string tag);
    op(1'b0, 1'b1, a, 32'h0, 1'b0, 8'h0, 1'b1, exp, 1'b0, tag);
  endtask

  task automatic push(input logic [7:0] c);
    op(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, c, 1'b0, 32'h0, 1'b0, "push");
  endtask

  initial begin
    idle();
    dmem_rdata = 32'h0;
    reset = 1'b1;
    mem_write = 1'b1;
    data_adr = 32'h40;
    #3;
    chk("rst_dmem_we", {31'h0, dmem_we}, 32'h0);
    chk("rst_bomb", bomb_q, 32'h0);
    chk("rst_enemy", enemy_q, 32'h0);
    chk("rst_pending", {31'h0, kb_pending}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    load(KBSTAT, 32'h0, "rst_kbstat");

    store(BOMB, 32'hDEADBEEF, "st_bomb");
    store(ENEMY, 32'h12345678, "st_enemy");
    chk("bomb_q", bomb_q, 32'hDEADBEEF);
    chk("enemy_q", enemy_q, 32'h12345678);
    load(BOMB, 32'hDEADBEEF, "ld_bomb");
    load(ENEMY, 32'h12345678, "ld_enemy");
    load(32'hFFFF_0008, 32'hDEADBEEF, "ld_bomb_hi_ignored");
    load(32'h0001_000B, 32'hDEADBEEF, "ld_bomb_lo_ignored");

    op(1'b1, 1'b0, 32'h40, 32'h1, 1'b0, 8'h0, 1'b0, 32'h0, 1'b1, "st_dmem");
    dmem_rdata = 32'hCAFEF00D;
    load(32'h40, 32'hCAFEF00D, "ld_dmem");
    load(32'hFFFE_0040, 32'hCAFEF00D, "ld_dmem_hi");

    push(8'h1C); push(8'h32); push(8'h5A);
    chk("pending3", {31'h0, kb_pending}, 32'h1);
    load(KBSTAT, 32'h0D, "stat3");
    load(KBDATA, 32'h1C, "pop0");
    load(KBSTAT, 32'h09, "stat2");
    load(KBDATA, 32'h32, "pop1");
    load(KBDATA, 32'h5A, "pop2");
    chk("pending0", {31'h0, kb_pending}, 32'h0);
    load(KBSTAT, 32'h0, "stat0");
    load(KBDATA, 32'h0, "pop_empty");

    for (int i = 0; i < 5; i++) push(8'h11 + 8'(i));
    load(KBSTAT, 32'h13, "stat_ovf");
    for (int i = 0; i < 4; i++) load(KBDATA, 32'h11 + 32'(i), "pop_ovf");
    load(KBSTAT, 32'h02, "stat_ovf_sticky");
    store(KBCTL, 32'h0, "st_kbctl");
    load(KBSTAT, 32'h0, "stat_clr");

    for (int i = 0; i < 4; i++) push(8'hA1 + 8'(i));
    op(1'b0, 1'b1, KBDATA, 32'h0, 1'b1, 8'h77, 1'b1, 32'hA1, 1'b0, "full_push_pop");
    load(KBSTAT, 32'h11, "stat_full_pp");
    for (int i = 0; i < 3; i++) load(KBDATA, 32'hA2 + 32'(i), "pop_full_pp");
    load(KBDATA, 32'h77, "pop_last77");
    load(KBDATA, 32'h0, "pop_empty2");

    op(1'b0, 1'b1, KBDATA, 32'h0, 1'b1, 8'h44, 1'b1, 32'h0, 1'b0, "empty_push_load");
    load(KBSTAT, 32'h05, "stat_after_epl");
    load(KBDATA, 32'h44, "pop44");

    push(8'h55);
    op(1'b1, 1'b0, KBCTL, 32'h0, 1'b1, 8'h66, 1'b0, 32'h0, 1'b0, "clr_vs_push");
    load(KBSTAT, 32'h0, "stat_clr_wins");

    push(8'h99);
    op(1'b1, 1'b1, KBDATA, 32'h0, 1'b0, 8'h0, 1'b0, 32'h0, 1'b0, "rw_kbdata");
    load(KBSTAT, 32'h05, "stat_rw_nopop");
    store(KBCTL, 32'h0, "st_kbctl2");

    store(32'h0001_0014, 32'hFFFFFFFF, "st_unmapped");
    load(32'h0001_0014, 32'h0, "ld_unmapped");
    load(KBCTL, 32'h0, "ld_kbctl");
    chk("bomb_unchanged", bomb_q, 32'hDEADBEEF);

    store(BOMB, 32'h5, "st_bomb5");
    push(8'hE1); push(8'hE2);
    #3;
    reset = 1'b1;
    mem_write = 1'b1;
    data_adr = 32'h40;
    #1;
    chk("arst_bomb", bomb_q, 32'h0);
    chk("arst_pending", {31'h0, kb_pending}, 32'h0);
    chk("arst_dmem_we", {31'h0, dmem_we}, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    idle();
    load(KBSTAT, 32'h0, "arst_kbstat");
    load(KBDATA, 32'h0, "arst_kbdata");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
